// File: rtl/vending_machine_fsm.sv
// Coin-operated vending controller: 15-unit product, 5/10-unit coins, registered pulse outputs.
// Optional idle-credit refund is compiled in when VENDING_REFUND_EN is defined.
module vending_machine_fsm #(
    parameter int unsigned IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] data,
    output logic [1:0] change,
    output logic       product
);

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_5       = 2'b01,
        COIN_10      = 2'b10,
        COIN_INVALID = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_5    = 2'b01,
        CHG_10   = 2'b10
    } change_e;

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 15) begin : g_idle_cycles_range
        $error("vending_machine_fsm: IDLE_CYCLES must be in 1..15");
    end

    state_e  state_q, state_d;
    change_e change_q, change_d;
    logic    product_q, product_d;
    coin_e   coin;

    assign coin = coin_e'(data);

`ifdef VENDING_REFUND_EN
    localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);

    logic [3:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S0;
            change_q  <= CHG_NONE;
            product_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            change_q  <= change_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        change_d  = CHG_NONE;
        product_d = 1'b0;
`ifdef VENDING_REFUND_EN
        idle_cnt_d = idle_cnt_q;
`endif

        unique case (coin)
            COIN_5: begin
`ifdef VENDING_REFUND_EN
                idle_cnt_d = '0;
`endif
                unique case (state_q)
                    S0:  state_d = S5;
                    S5:  state_d = S10;
                    S10: begin
                        state_d   = S0;
                        product_d = 1'b1;
                    end
                    default: state_d = S0;
                endcase
            end

            COIN_10: begin
`ifdef VENDING_REFUND_EN
                idle_cnt_d = '0;
`endif
                unique case (state_q)
                    S0: state_d = S10;
                    S5: begin
                        state_d   = S0;
                        product_d = 1'b1;
                    end
                    S10: begin
                        state_d   = S0;
                        product_d = 1'b1;
                        change_d  = CHG_5;
                    end
                    default: state_d = S0;
                endcase
            end

            COIN_NONE: begin
`ifdef VENDING_REFUND_EN
                // Credit is returned as the coin that matches it; counter resets with S0.
                if (state_q == S0) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = S0;
                    idle_cnt_d = '0;
                    change_d   = (state_q == S5) ? CHG_5 : CHG_10;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
`endif
            end

            default: begin
                // Invalid coin: credit and idle count held, nothing dispensed.
            end
        endcase
    end

    assign change  = change_q;
    assign product = product_q;

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Scoreboard bench for vending_machine_fsm: stimulus queues expected outputs, monitor checks them.
// Refund scenarios are exercised only when VENDING_REFUND_EN is defined.
module tb_vending_machine_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] data;
    logic [1:0] change;
    logic       product;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [2:0] resp;
    } exp_t;

    exp_t exp_q[$];

    vending_machine_fsm #(.IDLE_CYCLES(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .change  (change),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got change=%b product=%b, required change=%b product=%b",
                     name, act[2:1], act[0], req[2:1], req[0]);
        end
    endtask

    // Drive one coin for the next rising edge and queue the response expected after it.
    task automatic step(input logic [1:0] coin, input logic [1:0] exp_chg,
                        input logic exp_prod, input string name);
        exp_t e;
        data = coin;
        @(posedge clk);
        e.name = name;
        e.resp = {exp_chg, exp_prod};
        exp_q.push_back(e);
        #1;
    endtask

    // Pulses rst in the second half of the cycle, after the monitor has sampled.
    task automatic pulse_rst();
        #5;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Monitor: one response per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_hold", {change, product}, 3'b000);
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, {change, product}, e.resp);
            end
        end
    end

    initial begin
        forever begin
            @(posedge rst);
            #1;
            check("rst_async", {change, product}, 3'b000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pending;
        rst  = 1'b0;
        data = 2'b00;
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 5 then 10: exact price
        step(2'b01, 2'b00, 1'b0, "t1_s5");
        step(2'b10, 2'b00, 1'b1, "t1_sale");
        // 10 then 10: 5 back
        step(2'b10, 2'b00, 1'b0, "t2_s10");
        step(2'b10, 2'b01, 1'b1, "t2_sale_chg5");
        // three fives, then a quiet cycle
        step(2'b01, 2'b00, 1'b0, "t3_s5");
        step(2'b01, 2'b00, 1'b0, "t3_s10");
        step(2'b01, 2'b00, 1'b1, "t3_sale");
        step(2'b00, 2'b00, 1'b0, "t3_after");
        // invalid coins hold credit
        step(2'b01, 2'b00, 1'b0, "t4_s5");
        step(2'b11, 2'b00, 1'b0, "t4_inv1");
        step(2'b11, 2'b00, 1'b0, "t4_inv2");
        step(2'b10, 2'b00, 1'b1, "t4_sale");
        // idle in S0
        step(2'b00, 2'b00, 1'b0, "t5_s0_idle");
        step(2'b11, 2'b00, 1'b0, "t5_s0_inv");
        // 10 then 5
        step(2'b10, 2'b00, 1'b0, "t6_s10");
        step(2'b01, 2'b00, 1'b1, "t6_sale");
        // back-to-back sales, no stray pulses between
        step(2'b10, 2'b00, 1'b0, "t7_s10a");
        step(2'b10, 2'b01, 1'b1, "t7_sale_a");
        step(2'b10, 2'b00, 1'b0, "t7_s10b");
        step(2'b10, 2'b01, 1'b1, "t7_sale_b");
        step(2'b00, 2'b00, 1'b0, "t7_after");

`ifdef VENDING_REFUND_EN
        step(2'b01, 2'b00, 1'b0, "r_s5");
        step(2'b00, 2'b01, 1'b0, "r_refund5");
        step(2'b10, 2'b00, 1'b0, "r_s10");
        step(2'b00, 2'b10, 1'b0, "r_refund10");
        step(2'b00, 2'b00, 1'b0, "r_s0_idle");
        step(2'b01, 2'b00, 1'b0, "r_s5_fresh");
        step(2'b10, 2'b00, 1'b1, "r_sale_after_refund");
`else
        step(2'b01, 2'b00, 1'b0, "h_s5");
        step(2'b00, 2'b00, 1'b0, "h_idle1");
        step(2'b00, 2'b00, 1'b0, "h_idle2");
        step(2'b10, 2'b00, 1'b1, "h_sale");
        step(2'b10, 2'b00, 1'b0, "h_s10");
        step(2'b00, 2'b00, 1'b0, "h_idle3");
        step(2'b01, 2'b00, 1'b1, "h_sale2");
`endif

        // reset while a sale pulse is showing drops it at once
        step(2'b10, 2'b00, 1'b0, "ra_s10");
        step(2'b10, 2'b01, 1'b1, "ra_sale");
        pulse_rst();
        step(2'b00, 2'b00, 1'b0, "ra_after");
        // reset discards credit: 10, reset, 5 -> only S5
        step(2'b10, 2'b00, 1'b0, "rb_s10");
        pulse_rst();
        step(2'b01, 2'b00, 1'b0, "rb_s5_no_product");
        step(2'b10, 2'b00, 1'b1, "rb_sale");
        step(2'b00, 2'b00, 1'b0, "tail");

        repeat (2) @(negedge clk);
        #1;
        pending = exp_q.size();
        n_checks++;
        if (pending != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d unchecked responses, required 0", pending);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_fsm.md
VENDING_MACHINE_FSM -- requirements
Module: VendingMachineFSM

Interface
REQ-001 SHALL have parameter: IDLE_CYCLES, default 1, number of consecutive no-coin cycles (legal 1..15) before credit is refunded.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: data  input  2  coin sampled every rising edge: 00 none, 01 = 5 units, 10 = 10 units, 11 invalid.
REQ-005 SHALL have port: change  output  2  registered change/refund for one cycle: 00 none, 01 = 5 units, 10 = 10 units; 11 never driven.
REQ-006 SHALL have port: product  output  1  registered one-cycle pulse, product dispensed.

Function
REQ-007 SHALL price the product at 15 units.
REQ-008 SHALL implement three credit states: S0 (0), S5 (5), S10 (10).
REQ-009 SHALL move S0 to S5 on 01 and to S10 on 10, with product=0 and change=00.
REQ-010 SHALL move S5 to S10 on 01, with no outputs.
REQ-011 SHALL move S5 to S0 on 10, with product=1 and change=00 on the next cycle.
REQ-012 SHALL move S10 to S0 on 01, with product=1 and change=00.
REQ-013 SHALL move S10 to S0 on 10, with product=1 and change=01 (5 back).
REQ-014 SHALL treat 11 as invalid: state held, idle counter held, outputs 00/0.
REQ-015 SHALL register outputs: a response to the coin sampled at edge N appears after edge N and holds until edge N+1; otherwise outputs are 0.
REQ-016 SHALL drive product and change as single-cycle pulses, and SHALL NOT assert them in consecutive cycles without a new triggering coin.
REQ-017 SHALL, when refund is enabled (REQ-024), count consecutive 00 cycles in S5/S10; when the count reaches IDLE_CYCLES, return to S0 and pulse change=01 from S5 or change=10 from S10, with product=0.
REQ-018 SHALL clear the idle counter on any valid coin, on entering S0, and on refund; S0 with 00 SHALL stay in S0 with no outputs.
REQ-019 SHALL keep a transaction that completes with a sale free of additional refund; credit after a sale is always 0.
REQ-020 SHALL accept at most one coin per clock; there is no coin rejection — every valid coin is credited or causes a sale.

Reset
REQ-021 SHALL, while rst=1, force state S0, idle counter 0, change=00 and product=0 immediately, independent of clk.
REQ-022 SHALL discard credit on reset asserted mid-transaction, with no refund pulse.
REQ-023 SHALL sample the first coin at the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL support macro VENDING_REFUND_EN: when defined, idle refund per REQ-017 is compiled in.
REQ-025 SHALL, when VENDING_REFUND_EN is undefined, retain credit indefinitely on 00 (S5/S10 hold, no change output); IDLE_CYCLES is then unused and the counter is absent.

Verification
REQ-026 SHALL pass: reset, then 01,10 -> S5 then S0, product=1, change=00 one cycle after the 10 edge.
REQ-027 SHALL pass: 10,10 -> product=1, change=01 on the cycle after the second coin.
REQ-028 SHALL pass: 01,01,01 -> product=1, change=00 after the third coin; the next cycle outputs are 0.
REQ-029 SHALL pass: with REFUND_EN defined and IDLE_CYCLES=1, 01,00 -> change=01, product=0, state S0; 10,00 -> change=10.
REQ-030 SHALL pass: with REFUND_EN undefined, 01,00,00,10 -> no output during 00, then product=1 and change=00.
REQ-031 SHALL pass: 10 then rst pulsed mid-cycle -> outputs 0 immediately; subsequent 01 yields S5 with no product.
